rsa_modexp_ctrl: RTL and testbench



---
 rtl/rsa_modexp_ctrl.sv | 172 +++++++++++++++++
 tb/tb_rsa_modexp_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving a radix-2 Montgomery multiplier.
// Define RSA_SKIP_LEADING_ZERO_EN to bypass the squarings that precede the first one bit of e.
module rsa_modexp_ctrl #(
    parameter int K   = 2048,
    parameter int E_W = 2048
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req,
    input  logic [K-1:0]   msg,
    input  logic [E_W-1:0] e,
    input  logic [K-1:0]   m,
    input  logic [K-1:0]   r2,
    output logic           busy,
    output logic [K-1:0]   res,
    output logic           val,
    output logic [K-1:0]   mm_x,
    output logic [K-1:0]   mm_y,
    output logic [K-1:0]   mm_m,
    output logic           mm_req,
    input  logic [K-1:0]   mm_res,
    input  logic           mm_val
);
    localparam int IW = (E_W > 1) ? $clog2(E_W) : 1;

    typedef enum logic [2:0] {
        IDLE, CONV_ACC, CONV_MSG, SQR, MUL, STEP, FINAL, DONE
    } state_t;

    state_t         state;
    logic [K-1:0]   msg_r;
    logic [K-1:0]   r2_r;
    logic [K-1:0]   acc;
    logic [K-1:0]   mb;
    logic [E_W-1:0] e_r;
    logic [IW-1:0]  idx;

    logic [IW-1:0]  head_idx;
    logic [K-1:0]   head_mb;
    state_t         head_state;
`ifdef RSA_SKIP_LEADING_ZERO_EN
    logic           seen_one;
`endif

    // Entry into the next bit position; mb may be the value being captured this edge.
    always_comb begin
        head_idx = (state == CONV_MSG) ? IW'(E_W - 1) : idx - 1'b1;
        head_mb  = (state == CONV_MSG) ? mm_res : mb;
`ifdef RSA_SKIP_LEADING_ZERO_EN
        if (seen_one)
            head_state = SQR;
        else if (e_r[head_idx])
            head_state = MUL;
        else
            head_state = STEP;
`else
        head_state = SQR;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            val    <= 1'b0;
            mm_req <= 1'b0;
            res    <= '0;
            mm_x   <= '0;
            mm_y   <= '0;
            mm_m   <= '0;
            msg_r  <= '0;
            r2_r   <= '0;
            e_r    <= '0;
            acc    <= '0;
            mb     <= '0;
            idx    <= '0;
`ifdef RSA_SKIP_LEADING_ZERO_EN
            seen_one <= 1'b0;
`endif
        end else begin
            mm_req <= 1'b0;
            val    <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        msg_r  <= msg;
                        e_r    <= e;
                        mm_m   <= m;
                        r2_r   <= r2;
                        busy   <= 1'b1;
                        mm_x   <= K'(1);
                        mm_y   <= r2;
                        mm_req <= 1'b1;
                        state  <= CONV_ACC;
`ifdef RSA_SKIP_LEADING_ZERO_EN
                        seen_one <= 1'b0;
`endif
                    end
                end
                CONV_ACC: begin
                    if (mm_val) begin
                        acc    <= mm_res;
                        mm_x   <= msg_r;
                        mm_y   <= r2_r;
                        mm_req <= 1'b1;
                        state  <= CONV_MSG;
                    end
                end
                CONV_MSG: begin
                    if (mm_val) begin
                        mb     <= mm_res;
                        idx    <= head_idx;
                        state  <= head_state;
                        mm_x   <= acc;
                        mm_y   <= (head_state == SQR) ? acc : head_mb;
                        mm_req <= (head_state != STEP);
                    end
                end
                SQR: begin
                    if (mm_val) begin
                        acc <= mm_res;
                        if (e_r[idx]) begin
                            mm_x   <= mm_res;
                            mm_y   <= mb;
                            mm_req <= 1'b1;
                            state  <= MUL;
                        end else begin
                            state <= STEP;
                        end
                    end
                end
                MUL: begin
                    if (mm_val) begin
                        acc   <= mm_res;
                        state <= STEP;
`ifdef RSA_SKIP_LEADING_ZERO_EN
                        seen_one <= 1'b1;
`endif
                    end
                end
                STEP: begin
                    if (idx == '0) begin
                        mm_x   <= acc;
                        mm_y   <= K'(1);
                        mm_req <= 1'b1;
                        state  <= FINAL;
                    end else begin
                        idx    <= head_idx;
                        state  <= head_state;
                        mm_x   <= acc;
                        mm_y   <= (head_state == SQR) ? acc : head_mb;
                        mm_req <= (head_state != STEP);
                    end
                end
                FINAL: begin
                    if (mm_val) begin
                        res   <= mm_res;
                        val   <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// Self-checking bench for rsa_modexp_ctrl with a behavioural Montgomery multiplier (K=8, m=187).
// Follows RSA_SKIP_LEADING_ZERO_EN when it is defined for the build.
module tb_rsa_modexp_ctrl;
    localparam int K   = 8;
    localparam int E_W = 8;
    localparam int M   = 187;
    localparam int R2  = 86;
`ifdef RSA_SKIP_LEADING_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           req;
    logic [K-1:0]   msg;
    logic [E_W-1:0] e;
    logic [K-1:0]   m;
    logic [K-1:0]   r2;
    logic           busy;
    logic [K-1:0]   res;
    logic           val;
    logic [K-1:0]   mm_x;
    logic [K-1:0]   mm_y;
    logic [K-1:0]   mm_m;
    logic           mm_req;
    logic [K-1:0]   mm_res = '0;
    logic           mm_val = 1'b0;

    int checks = 0;
    int errors = 0;
    int req_total = 0;
    int val_total = 0;
    int job_req_start = 0;
    bit job_open = 1'b0;
    int exp_res = 0;
    int exp_ops = 0;
    int exp_m = 0;
    int exp_r2 = 0;

    bit           mult_pending = 1'b0;
    int           mult_cnt = 0;
    logic [K-1:0] mult_x, mult_y, mult_m;

    rsa_modexp_ctrl #(.K(K), .E_W(E_W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .msg(msg), .e(e), .m(m), .r2(r2),
        .busy(busy), .res(res), .val(val), .mm_x(mm_x), .mm_y(mm_y), .mm_m(mm_m),
        .mm_req(mm_req), .mm_res(mm_res), .mm_val(mm_val)
    );

    always #5 clk = ~clk;

    // x*y*R^-1 mod m, found by searching for t with t*R == x*y (mod m)
    function automatic int mont(int x, int y, int mod_v);
        for (int t = 0; t < mod_v; t++)
            if (((t * (1 << K)) % mod_v) == ((x * y) % mod_v)) return t;
        return 0;
    endfunction

    function automatic int modexp(int b, int ex, int mod_v);
        int r = 1 % mod_v;
        for (int i = 0; i < ex; i++) r = (r * b) % mod_v;
        return r;
    endfunction

    function automatic int expectedOps(int ex);
        int pop = 0;
        int msb = 0;
        for (int b = 0; b < E_W; b++)
            if (ex[b]) begin
                pop++;
                msb = b;
            end
        return SKIP ? (3 + pop + msb) : (3 + E_W + pop);
    endfunction

    // Multiplier model: answers each mm_req two cycles later with a single mm_val pulse.
    always @(posedge clk) begin
        #2;
        if (!rst_n) begin
            mm_val = 1'b0;
            mult_pending = 1'b0;
        end else begin
            mm_val = 1'b0;
            if (mm_req) begin
                mult_pending = 1'b1;
                mult_cnt = 2;
                mult_x = mm_x;
                mult_y = mm_y;
                mult_m = mm_m;
            end else if (mult_pending) begin
                mult_cnt--;
                if (mult_cnt == 0) begin
                    mm_res = K'(mont(int'(mult_x), int'(mult_y), int'(mult_m)));
                    mm_val = 1'b1;
                    mult_pending = 1'b0;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic monitorLoop();
        bit prev_req = 1'b0;
        bit outstanding = 1'b0;
        logic [K-1:0] sx, sy, sm;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_req = 1'b0;
                outstanding = 1'b0;
            end else begin
                if (mm_req) begin
                    checkOutput("mm_req_single_cycle", int'(prev_req), 0);
                    checkOutput("mm_req_before_val", int'(outstanding), 0);
                    checkOutput("mm_m_value", int'(mm_m), exp_m);
                    checkOutput("busy_during_op", int'(busy), 1);
                    if (req_total == job_req_start) begin
                        checkOutput("first_op_x", int'(mm_x), 1);
                        checkOutput("first_op_y", int'(mm_y), exp_r2);
                    end
                    req_total++;
                    outstanding = 1'b1;
                    sx = mm_x;
                    sy = mm_y;
                    sm = mm_m;
                end else if (outstanding) begin
                    checkOutput("mm_x_stable", int'(mm_x), int'(sx));
                    checkOutput("mm_y_stable", int'(mm_y), int'(sy));
                    checkOutput("mm_m_stable", int'(mm_m), int'(sm));
                end
                if (mm_val) outstanding = 1'b0;
                prev_req = mm_req;
                if (val) begin
                    checkOutput("val_expected", int'(job_open), 1);
                    checkOutput("res_value", int'(res), exp_res);
                    checkOutput("busy_low_with_val", int'(busy), 0);
                    checkOutput("op_count", req_total - job_req_start, exp_ops);
                    job_open = 1'b0;
                    val_total++;
                end
            end
        end
    endtask

    task automatic applyStimulus(input int msg_v, input int e_v, input int lit_res, input int lit_ops);
        @(negedge clk);
        checkOutput("idle_busy", int'(busy), 0);
        checkOutput("idle_val", int'(val), 0);
        exp_res = modexp(msg_v, e_v, M);
        exp_ops = expectedOps(e_v);
        checkOutput("model_res", exp_res, lit_res);
        checkOutput("model_ops", exp_ops, lit_ops);
        exp_m = M;
        exp_r2 = R2;
        msg = K'(msg_v);
        e = E_W'(e_v);
        m = K'(M);
        r2 = K'(R2);
        job_req_start = req_total;
        job_open = 1'b1;
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        checkOutput("busy_after_accept", int'(busy), 1);
    endtask

    task automatic waitForVal(input int max_cycles);
        int n = 0;
        while (!val && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        if (!val) begin
            checkOutput("val_timeout", 0, 1);
            job_open = 1'b0;
        end
    endtask

    initial begin
        int n;
        int vt;
        req = 1'b0;
        msg = '0;
        e = '0;
        m = '0;
        r2 = '0;
        rst_n = 1'b1;
        fork
            monitorLoop();
        join_none
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_val", int'(val), 0);
        checkOutput("reset_mm_req", int'(mm_req), 0);
        checkOutput("reset_res", int'(res), 0);
        checkOutput("reset_mm_m", int'(mm_m), 0);
        rst_n = 1'b1;
        checkOutput("model_mont", mont(R2, 1, M), 69);

        $display("[TB] job msg=88 e=7");
        applyStimulus(88, 7, 11, SKIP ? 8 : 14);
        waitForVal(2000);

        $display("[TB] job msg=5 e=0");
        applyStimulus(5, 0, 1, SKIP ? 3 : 11);
        waitForVal(2000);

        // A second request mid-job carries a different operand that must not leak into the result.
        $display("[TB] job msg=0 e=0x80 with ignored second req");
        applyStimulus(0, 8'h80, 0, SKIP ? 11 : 12);
        repeat (6) @(negedge clk);
        msg = 8'd3;
        e = 8'd1;
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        waitForVal(2000);
        repeat (10) @(negedge clk);

        $display("[TB] reset mid-job");
        applyStimulus(88, 7, 11, SKIP ? 8 : 14);
        n = 0;
        while ((req_total - job_req_start) < 4 && n < 500) begin
            @(posedge clk);
            n++;
        end
        checkOutput("fourth_req_seen", req_total - job_req_start, 4);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        job_open = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_val", int'(val), 0);
        checkOutput("abort_mm_req", int'(mm_req), 0);
        checkOutput("abort_res", int'(res), 0);
        checkOutput("abort_mm_x", int'(mm_x), 0);
        checkOutput("abort_mm_y", int'(mm_y), 0);
        checkOutput("abort_mm_m", int'(mm_m), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        vt = val_total;
        repeat (20) @(negedge clk);
        checkOutput("no_val_after_abort", val_total, vt);

        $display("[TB] job after reset, then back-to-back job");
        applyStimulus(88, 7, 11, SKIP ? 8 : 14);
        waitForVal(2000);
        applyStimulus(2, 10, 89, SKIP ? 8 : 13);
        waitForVal(2000);
        repeat (5) @(negedge clk);
        checkOutput("res_held", int'(res), 89);
        checkOutput("val_total", val_total, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
